// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline stall/flush/redirect controller (RUN/MEMWAIT/DRAIN FSM).
// Define PIPE_PERF_EN to enable the saturating stall_cycles/flush_cnt counters.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_busy,
  input  logic        dmem_busy,
  input  logic        load_use,
  input  logic        redirect_req,
  input  logic [63:0] redirect_pc,
  input  logic        fence_req,
  input  logic [2:0]  stage_valid,
  output logic        en_f,
  output logic        en_fd,
  output logic        en_de,
  output logic        en_em,
  output logic        en_mw,
  output logic        clr_fd,
  output logic        clr_de,
  output logic        clr_em,
  output logic        clr_mw,
  output logic        pc_sel,
  output logic [63:0] pc_redirect,
  output logic [1:0]  state,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cnt
);
  localparam logic [1:0] RUN = 2'd0, MEMWAIT = 2'd1, DRAIN = 2'd2;
  logic [1:0]  state_q, state_d;
  logic        pend_v_q, pend_v_d;
  logic [63:0] pend_pc_q, pend_pc_d;
  logic        redir, stall_de, stall_f;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      pend_v_q  <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
    end
  end
  // The MEMWAIT exit cycle is evaluated like RUN, with any parked redirect merged in.
  always_comb begin
    redir     = 1'b0;
    stall_de  = 1'b0;
    stall_f   = 1'b0;
    state_d   = RUN;
    pend_v_d  = 1'b0;
    pend_pc_d = pend_pc_q;
    if (dmem_busy) begin
      state_d   = MEMWAIT;
      pend_v_d  = pend_v_q | redirect_req;
      pend_pc_d = redirect_req ? redirect_pc : pend_pc_q;
    end else begin
      case (state_q)
        RUN, MEMWAIT: begin
          redir    = redirect_req | (state_q == MEMWAIT && pend_v_q);
          stall_de = !redir && (fence_req || load_use);
          stall_f  = !redir && !stall_de && imem_busy;
          state_d  = (state_q == RUN && !redir && fence_req) ? DRAIN : RUN;
        end
        DRAIN: begin
          redir    = redirect_req;
          stall_de = !redirect_req;
          state_d  = (!redirect_req && stage_valid != 3'b000) ? DRAIN : RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end
  always_comb begin
    en_f        = !rst || !(dmem_busy || stall_de || stall_f);
    en_fd       = !rst || !(dmem_busy || stall_de);
    en_de       = !rst || !dmem_busy;
    en_em       = !rst || !dmem_busy;
    en_mw       = !rst || !dmem_busy;
    clr_fd      = !rst || redir || stall_f;
    clr_de      = !rst || redir || stall_de;
    clr_em      = !rst;
    clr_mw      = !rst;
    pc_sel      = rst && redir;
    pc_redirect = !pc_sel ? 64'd0 : redirect_req ? redirect_pc : pend_pc_q;
    state       = state_q;
  end
`ifdef PIPE_PERF_EN
  logic [31:0] stall_q, flush_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= (!en_f && stall_q != '1) ? stall_q + 32'd1 : stall_q;
      flush_q <= (pc_sel && flush_q != '1) ? flush_q + 32'd1 : flush_q;
    end
  end
  assign stall_cycles = stall_q;
  assign flush_cnt    = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_cnt    = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed + randomized checks of pipe_ctrl against an action-level model.
module tb_pipe_ctrl;
  logic        clk = 0, rst = 1;
  logic        imem_busy = 0, dmem_busy = 0, load_use = 0, redirect_req = 0, fence_req = 0;
  logic [63:0] redirect_pc = '0;
  logic [2:0]  stage_valid = '0;
  logic        en_f, en_fd, en_de, en_em, en_mw, clr_fd, clr_de, clr_em, clr_mw, pc_sel;
  logic [63:0] pc_redirect;
  logic [1:0]  state;
  logic [31:0] stall_cycles, flush_cnt;
  int checks = 0, errors = 0;
  bit started = 0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .imem_busy(imem_busy), .dmem_busy(dmem_busy), .load_use(load_use),
    .redirect_req(redirect_req), .redirect_pc(redirect_pc), .fence_req(fence_req),
    .stage_valid(stage_valid), .en_f(en_f), .en_fd(en_fd), .en_de(en_de), .en_em(en_em),
    .en_mw(en_mw), .clr_fd(clr_fd), .clr_de(clr_de), .clr_em(clr_em), .clr_mw(clr_mw),
    .pc_sel(pc_sel), .pc_redirect(pc_redirect), .state(state),
    .stall_cycles(stall_cycles), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Model: per-cycle pipeline "action", then a lookup of what each action drives.
  localparam int A_RESET = 0, A_FREEZE = 1, A_REDIR = 2, A_HOLD_DE = 3, A_HOLD_F = 4, A_NONE = 5;
  int          m_state = 0;
  bit          m_pend_v = 0;
  logic [63:0] m_pend_pc = '0;
  longint      m_stall = 0, m_flush = 0;

  function automatic int action();
    if (!rst) return A_RESET;
    if (dmem_busy) return A_FREEZE;
    if (redirect_req || m_pend_v) return A_REDIR;
    if (m_state == 2 || fence_req || load_use) return A_HOLD_DE;
    if (imem_busy) return A_HOLD_F;
    return A_NONE;
  endfunction

  // {en_f,en_fd,en_de,en_em,en_mw, clr_fd,clr_de,clr_em,clr_mw, pc_sel}
  function automatic logic [9:0] out_vec(int a);
    case (a)
      A_RESET:   return 10'b11111_1111_0;
      A_FREEZE:  return 10'b00000_0000_0;
      A_REDIR:   return 10'b11111_1100_1;
      A_HOLD_DE: return 10'b00111_0100_0;
      A_HOLD_F:  return 10'b01111_1000_0;
      default:   return 10'b11111_0000_0;
    endcase
  endfunction

  function automatic int next_state(int a);
    if (a == A_FREEZE) return 1;
    if (a == A_REDIR) return 0;
    if (m_state == 2) return (stage_valid == 3'b000) ? 0 : 2;
    return (m_state == 0 && fence_req) ? 2 : 0;
  endfunction

  function automatic logic [63:0] exp_pc(int a);
    return (a != A_REDIR) ? 64'd0 : redirect_req ? redirect_pc : m_pend_pc;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state <= 0; m_pend_v <= 0; m_pend_pc <= '0; m_stall <= 0; m_flush <= 0;
    end else begin
      m_state <= next_state(action());
      if (action() == A_FREEZE && redirect_req) begin
        m_pend_v <= 1; m_pend_pc <= redirect_pc;
      end else if (action() != A_FREEZE) m_pend_v <= 0;
      if (out_vec(action())[9] == 1'b0) m_stall <= (m_stall < 64'hFFFF_FFFF) ? m_stall + 1 : m_stall;
      if (action() == A_REDIR) m_flush <= (m_flush < 64'hFFFF_FFFF) ? m_flush + 1 : m_flush;
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [9:0] dut_vec();
    return {en_f, en_fd, en_de, en_em, en_mw, clr_fd, clr_de, clr_em, clr_mw, pc_sel};
  endfunction

  always @(negedge clk) begin
    if (started) begin
      chk("model_outs", {54'd0, dut_vec()}, {54'd0, out_vec(action())});
      chk("model_pc", pc_redirect, exp_pc(action()));
      chk("model_state", {62'd0, state}, 64'(m_state));
`ifdef PIPE_PERF_EN
      chk("model_stall", {32'd0, stall_cycles}, 64'(m_stall));
      chk("model_flush", {32'd0, flush_cnt}, 64'(m_flush));
`else
      chk("model_stall", {32'd0, stall_cycles}, 64'd0);
      chk("model_flush", {32'd0, flush_cnt}, 64'd0);
`endif
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    imem_busy = 0; dmem_busy = 0; load_use = 0; redirect_req = 0; fence_req = 0;
    redirect_pc = '0; stage_valid = '0;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #2 rst = 0; dmem_busy = 1;
    started = 1;
    sample();
    chk("rst_en", {59'd0, en_f, en_fd, en_de, en_em, en_mw}, 64'h1F);
    chk("rst_clr", {60'd0, clr_fd, clr_de, clr_em, clr_mw}, 64'hF);
    chk("rst_state", {62'd0, state}, 64'd0);
    step(); rst = 1; idle(); sample();
    chk("post_rst_outs", {54'd0, dut_vec()}, {54'd0, 10'b11111_0000_0});
    step(); load_use = 1; sample();
    chk("lu_outs", {60'd0, en_f, en_fd, clr_de, en_em}, 64'b0011);
    step(); idle(); sample();
    chk("lu_after", {54'd0, dut_vec()}, {54'd0, 10'b11111_0000_0});
    step(); dmem_busy = 1; sample();
    chk("mw_c1_en", {59'd0, en_f, en_fd, en_de, en_em, en_mw}, 64'd0);
    step(); redirect_req = 1; redirect_pc = 64'h8000_0040; sample();
    chk("mw_c2_en", {59'd0, en_f, en_fd, en_de, en_em, en_mw}, 64'd0);
    chk("mw_c2_state", {62'd0, state}, 64'd1);
    step(); redirect_req = 0; redirect_pc = '0; sample();
    chk("mw_c3_state", {62'd0, state}, 64'd1);
    step(); dmem_busy = 0; sample();
    chk("mw_c4_sel", {62'd0, pc_sel, clr_fd & clr_de}, 64'b11);
    chk("mw_c4_pc", pc_redirect, 64'h8000_0040);
    step(); sample();
    chk("mw_c5_state", {62'd0, state}, 64'd0);
    chk("mw_c5_pc", {63'd0, pc_sel}, 64'd0);
    step(); dmem_busy = 1; redirect_req = 1; redirect_pc = 64'h100; sample();
    chk("same_freeze", {54'd0, dut_vec()}, 64'd0);
    step(); idle(); sample();
    chk("same_pc", pc_redirect, 64'h100);
    step(); fence_req = 1; stage_valid = 3'b111; sample();
    chk("fence_entry", {61'd0, en_f, clr_de, state == 2'd0}, 64'b011);
    for (int i = 0; i < 4; i++) begin
      step(); fence_req = 0; stage_valid = (i == 0) ? 3'b111 : (i == 1) ? 3'b110 : (i == 2) ? 3'b100 : 3'b000;
      sample();
      chk("drain", {60'd0, state, en_f, clr_de}, 64'b1001);
    end
    step(); idle(); sample();
    chk("drain_exit", {62'd0, state}, 64'd0);
    step(); dmem_busy = 1; redirect_req = 1; redirect_pc = 64'h200;
    step(); redirect_req = 0;
    step(); rst = 0; idle(); sample();
    chk("rst_mid_state", {62'd0, state}, 64'd0);
    step(); rst = 1; sample();
    chk("rst_mid_pend", {62'd0, pc_sel, state != 2'd0}, 64'd0);
    step(); rst = 0; step(); rst = 1;
    load_use = 1; repeat (5) step();
    load_use = 0; redirect_req = 1; redirect_pc = 64'h44; repeat (2) step();
    idle(); sample();
`ifdef PIPE_PERF_EN
    chk("perf_stall", {32'd0, stall_cycles}, 64'd5);
    chk("perf_flush", {32'd0, flush_cnt}, 64'd2);
`else
    chk("perf_stall", {32'd0, stall_cycles}, 64'd0);
    chk("perf_flush", {32'd0, flush_cnt}, 64'd0);
`endif
    for (int n = 0; n < 3000; n++) begin
      step();
      rst          = ($urandom_range(0, 99) >= 2);
      dmem_busy    = ($urandom_range(0, 99) < 25);
      redirect_req = ($urandom_range(0, 99) < 15);
      redirect_pc  = {$urandom, $urandom};
      fence_req    = ($urandom_range(0, 99) < 10);
      load_use     = ($urandom_range(0, 99) < 20);
      imem_busy    = ($urandom_range(0, 99) < 25);
      stage_valid  = ($urandom_range(0, 99) < 30) ? 3'b000 : 3'($urandom);
    end
    step(); rst = 1; idle(); sample();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  asynchronous reset, active-low.
REQ-003 SHALL have ports imem_busy, dmem_busy  in  1 each  fetch or memory stage waiting on bus.
REQ-004 SHALL have port load_use  in  1  decode-stage load-use hazard.
REQ-005 SHALL have ports redirect_req  in  1, redirect_pc  in  64  branch mispredict/jump from execute.
REQ-006 SHALL have ports fence_req  in  1, stage_valid  in  3  fence in decode; valid bits {W,M,E}.
REQ-007 SHALL have ports en_f, en_fd, en_de, en_em, en_mw  out  1 each  PC and IF/ID, ID/EX, EX/MEM, MEM/WB register enables.
REQ-008 SHALL have ports clr_fd, clr_de, clr_em, clr_mw  out  1 each  bubble insert; the pipe registers honour clr only while their en=1.
REQ-009 SHALL have ports pc_sel  out  1, pc_redirect  out  64  PC override.
REQ-010 SHALL have ports state  out  2, stall_cycles  out  32, flush_cnt  out  32.

Function
REQ-011 SHALL implement FSM RUN=0, MEMWAIT=1, DRAIN=2; encoding 3 unreachable and SHALL return to RUN.
REQ-012 Default (no event) outputs SHALL be all en=1, all clr=0, pc_sel=0.
REQ-013 In RUN, event priority SHALL be dmem_busy > redirect_req > fence_req > load_use > imem_busy.
REQ-014 dmem_busy in any state SHALL drive all en=0 and all clr=0 that cycle (whole-pipe freeze), next state MEMWAIT.
REQ-015 MEMWAIT SHALL hold while dmem_busy=1; on redirect_req there SHALL latch pend_v=1, pend_pc=redirect_pc (last value wins).
REQ-016 First cycle with dmem_busy=0 in MEMWAIT SHALL return to RUN and apply a redirect if redirect_req or pend_v: pc source redirect_pc if redirect_req else pend_pc; pend_v cleared that edge.
REQ-017 Redirect SHALL drive pc_sel=1, pc_redirect per REQ-016, all en=1, clr_fd=clr_de=1, for exactly one cycle; zero-cycle latency from redirect_req.
REQ-018 load_use SHALL drive en_f=0, en_fd=0, en_de=1 with clr_de=1, en_em=en_mw=1.
REQ-019 imem_busy alone SHALL drive en_f=0, en_fd=1 with clr_fd=1, others default.
REQ-020 fence_req in RUN SHALL enter DRAIN; DRAIN (including entry cycle) SHALL drive en_f=0, en_fd=0, en_de=1 with clr_de=1.
REQ-021 DRAIN SHALL return to RUN on the edge where stage_valid==3'b000 is sampled; redirect_req in DRAIN SHALL apply per REQ-017 and exit to RUN.
REQ-022 pc_redirect SHALL equal 0 whenever pc_sel=0.
REQ-023 state SHALL reflect the registered FSM state.

Reset
REQ-024 rst=0 SHALL asynchronously force state=RUN, pend_v=0, pend_pc=0, stall_cycles=0, flush_cnt=0.
REQ-025 During reset, outputs SHALL be all en=1, clr_fd=clr_de=clr_em=clr_mw=1, pc_sel=0, so pipe registers load bubbles.
REQ-026 Reset release mid-MEMWAIT or mid-DRAIN SHALL discard pending redirect; first post-reset cycle in RUN.

Configuration
REQ-027 Macro PIPE_PERF_EN defined: stall_cycles SHALL count cycles with en_f=0; flush_cnt SHALL count redirect cycles; both saturate at 32'hFFFF_FFFF.
REQ-028 PIPE_PERF_EN undefined: ports SHALL remain, driven constant 0, no counter flops.

Verification
REQ-029 rst=0 with dmem_busy=1 -> all en=1, all clr=1, state=0; release -> state=0, default outputs.
REQ-030 load_use=1 one cycle -> en_f=0, en_fd=0, clr_de=1, en_em=1; next cycle defaults.
REQ-031 dmem_busy=1 for 3 cycles, redirect_req=1 pc=0x8000_0040 in cycle 2 only -> all en=0 cycles 1-3, state=1; cycle 4 pc_sel=1, pc_redirect=0x8000_0040, clr_fd=clr_de=1, state back 0.
REQ-032 dmem_busy=1 and redirect_req=1 pc=0x100 same RUN cycle -> freeze; redirect applied first cycle dmem_busy=0.
REQ-033 fence_req=1, stage_valid 3'b111,3'b110,3'b100,3'b000 -> state=2 for 4 cycles, en_f=0, clr_de=1; then state=0.
REQ-034 PIPE_PERF_EN defined, 5 stall cycles + 2 redirects -> stall_cycles=5, flush_cnt=2; undefined -> both 0.
